// File: rtl/fx_pt_add_pipe.sv
// Two-stage fixed-point adder/accumulator with valid/ready streams.
// Supports unsigned, two's complement and sign-magnitude operands.
module fx_pt_add_pipe #(
    parameter int WIDTH  = 15,
    parameter int A_FRAC = 1,
    parameter int B_FRAC = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic               in_acc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH:0]   sum,
    output logic               sat
);

    localparam int F     = (A_FRAC > B_FRAC) ? A_FRAC : B_FRAC;
    localparam int SUM_W = 2 * WIDTH + 1;
    localparam int IW    = SUM_W + 2;
    localparam int SH_A  = F - A_FRAC;
    localparam int SH_B  = F - B_FRAC;

    typedef logic signed [IW-1:0] ival_t;

    localparam ival_t ZERO  = ival_t'(0);
    localparam ival_t ONE   = ival_t'(1);
    localparam ival_t U_MAX = (ONE <<< SUM_W) - ONE;
    localparam ival_t S_MAX = (ONE <<< (SUM_W - 1)) - ONE;
    localparam ival_t S_MIN = -(ONE <<< (SUM_W - 1));
    localparam ival_t M_MIN = -S_MAX;

    function automatic ival_t decode(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       m
    );
        ival_t mag;
        ival_t v;
        mag = ival_t'(x[WIDTH-2:0]);
        v   = ival_t'(x);
        unique case (1'b1)
            m == 2'd0: v = ival_t'(x);
            m == 2'd1: v = ival_t'($signed(x));
            m[1]:      v = x[WIDTH-1] ? -mag : mag;
        endcase
        return v;
    endfunction

    logic       s1_valid;
    logic [1:0] s1_mode;
    logic       s1_acc;
    ival_t      s1_a;
    ival_t      s1_b;
    ival_t      acc;

    logic s2_adv;
    assign s2_adv   = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Operand payload needs no reset: it is qualified by s1_valid.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_mode <= in_mode;
            s1_acc  <= in_acc;
            s1_a    <= decode(a, in_mode) <<< SH_A;
            s1_b    <= decode(b, in_mode) <<< SH_B;
        end
    end

    ival_t              r;
    ival_t              rc;
    ival_t              lo;
    ival_t              hi;
    logic [SUM_W-2:0]   mag;
    logic [SUM_W-1:0]   sum_d;
    logic               sat_d;

    always_comb begin
        r     = (s1_acc ? acc : ZERO) + s1_a + s1_b;
        lo    = ZERO;
        hi    = U_MAX;
        unique case (1'b1)
            s1_mode == 2'd0: begin lo = ZERO;  hi = U_MAX; end
            s1_mode == 2'd1: begin lo = S_MIN; hi = S_MAX; end
            s1_mode[1]:      begin lo = M_MIN; hi = S_MAX; end
        endcase
        rc    = r;
        sat_d = 1'b0;
        if (r > hi) begin
            rc    = hi;
            sat_d = 1'b1;
        end else if (r < lo) begin
            rc    = lo;
            sat_d = 1'b1;
        end
        mag   = (SUM_W-1)'((rc < 0) ? -rc : rc);
        // Sign comes from the value itself, so zero always encodes as +0.
        sum_d = s1_mode[1] ? {rc < 0, mag} : rc[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            sat       <= 1'b0;
            acc       <= ZERO;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum <= sum_d;
                sat <= sat_d;
                acc <= rc;
            end
        end
    end

endmodule

// File: tb/tb_fx_pt_add_pipe.sv
// Scoreboard bench for fx_pt_add_pipe at WIDTH=8, A_FRAC=4, B_FRAC=2.
// Expected results are computed from an integer model at input transfer.
module tb_fx_pt_add_pipe;

    localparam int W  = 8;
    localparam int SW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_mode = 2'd0;
    logic          in_acc = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] sum;
    logic          sat;

    always #5 clk = ~clk;

    fx_pt_add_pipe #(
        .WIDTH  (W),
        .A_FRAC (4),
        .B_FRAC (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_acc    (in_acc),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .sat       (sat)
    );

    typedef struct packed {
        logic [SW-1:0] s;
        logic          t;
    } exp_t;

    exp_t          q[$];
    longint        macc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    logic          held_v = 1'b0;
    logic [SW-1:0] held_s;
    logic          held_t;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t kx(input logic [SW-1:0] s, input logic t);
        exp_t e;
        e.s = s;
        e.t = t;
        return e;
    endfunction

    function automatic longint dec(input logic [7:0] x, input logic [1:0] m);
        if (m == 2'd0) return longint'(x);
        if (m == 2'd1) return x[7] ? longint'(x) - 256 : longint'(x);
        return x[7] ? -longint'(x[6:0]) : longint'(x[6:0]);
    endfunction

    function automatic exp_t model(input logic [1:0] m, input logic ac,
                                   input logic [7:0] aa, input logic [7:0] bb);
        longint r, lo, hi, mg;
        exp_t   e;
        r = (ac ? macc : 0) + dec(aa, m) + dec(bb, m) * 4;
        if (m == 2'd0) begin
            lo = 0;
            hi = 131071;
        end else if (m == 2'd1) begin
            lo = -65536;
            hi = 65535;
        end else begin
            lo = -65535;
            hi = 65535;
        end
        e.t = 1'b0;
        if (r > hi) begin
            r   = hi;
            e.t = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            e.t = 1'b1;
        end
        macc = r;
        if (m[1]) begin
            mg  = (r < 0) ? -r : r;
            e.s = {(r < 0), mg[15:0]};
        end else begin
            e.s = r[16:0];
        end
        return e;
    endfunction

    task automatic cycle(input logic iv, input logic [1:0] m, input logic ac,
                         input logic [7:0] aa, input logic [7:0] bb,
                         input logic ordy, input logic use_k, input exp_t k,
                         output logic took, output logic ov);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        in_mode   = m;
        in_acc    = ac;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        #1;
        ov = out_valid;
        if (held_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, held_s);
            chk("hold_sat", sat, held_t);
        end
        held_v = 1'b0;
        chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious", out_valid, 0);
            end else if (ordy) begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("sat", sat, e.t);
            end else begin
                held_v = 1'b1;
                held_s = sum;
                held_t = sat;
            end
        end
        took = iv & in_ready;
        if (took) begin
            e = model(m, ac, aa, bb);
            if (use_k) e = k;
            q.push_back(e);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic ac,
                        input logic [7:0] aa, input logic [7:0] bb,
                        input logic use_k, input exp_t k);
        logic took, ov;
        int   tries;
        took  = 1'b0;
        tries = 0;
        while (!took && tries < 50) begin
            cycle(1'b1, m, ac, aa, bb, 1'b1, use_k, k, took, ov);
            tries++;
        end
        chk("send_timeout", took, 1);
    endtask

    task automatic drain();
        logic took, ov;
        int   tries;
        tries = 0;
        while (q.size() != 0 && tries < 20) begin
            cycle(1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, '0, took, ov);
            tries++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        a         = 8'hFF;
        b         = 8'hFF;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_valid", out_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_sat", sat, 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        macc   = 0;
        held_v = 1'b0;
    endtask

    initial begin
        logic       took, ov;
        logic [3:0] pat;
        int         i, cyc;

        do_reset();

        cycle(1'b1, 2'd0, 1'b0, 8'h18, 8'h06, 1'b1, 1'b1,
              kx(17'h00030, 1'b0), took, ov);
        chk("lat_took", took, 1);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, '0, took, ov);
        chk("lat_cyc1", ov, 0);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, '0, took, ov);
        chk("lat_cyc2", ov, 1);

        send(2'd1, 1'b0, 8'hF0, 8'h01, 1'b1, kx(17'h1FFF4, 1'b0));
        send(2'd2, 1'b0, 8'h88, 8'h01, 1'b1, kx(17'h10004, 1'b0));
        send(2'd3, 1'b0, 8'h80, 8'h80, 1'b1, kx(17'h00000, 1'b0));
        send(2'd2, 1'b0, 8'h81, 8'h01, 1'b1, kx(17'h00003, 1'b0));
        drain();

        pat = 4'b1001;
        i   = 0;
        cyc = 0;
        while ((i < 6 || q.size() != 0) && cyc < 100) begin
            cycle(i < 6, 2'(i % 3), 1'(i % 2), 8'($urandom), 8'($urandom),
                  pat[cyc % 4], 1'b0, '0, took, ov);
            if (took) i++;
            cyc++;
        end
        chk("bp_sent", i, 6);
        drain();

        send(2'd0, 1'b0, 8'hFF, 8'hFF, 1'b0, '0);
        for (int k = 2; k <= 101; k++) send(2'd0, 1'b1, 8'hFF, 8'hFF, 1'b0, '0);
        send(2'd0, 1'b1, 8'hFF, 8'hFF, 1'b1, kx(17'd130050, 1'b0));
        send(2'd0, 1'b1, 8'hFF, 8'hFF, 1'b1, kx(17'h1FFFF, 1'b1));
        send(2'd1, 1'b0, 8'h01, 8'h00, 1'b1, kx(17'h00001, 1'b0));
        drain();

        for (int k = 0; k < 60; k++) begin
            cycle(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom), 1'b0, '0, took, ov);
        end
        drain();

        send(2'd0, 1'b0, 8'h40, 8'h20, 1'b0, '0);
        send(2'd1, 1'b1, 8'h7F, 8'h10, 1'b0, '0);
        do_reset();
        send(2'd0, 1'b1, 8'h01, 8'h00, 1'b1, kx(17'h00001, 1'b0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
